case_6_sdiv_13s_7s_13_seq_1: RTL

- Multi-cycle signed integer divider; the arithmetic inverse of the case_6 signed multiplier datapath.
- Recovers quotient and remainder from a 13-bit signed product and a 7-bit signed factor.
- Radix-2 restoring iterative core with a start/done handshake and clock enable.
- Sits in the case_6 datapath wherever HLS schedules a signed "/" or "%" as a multi-cycle operator.

---
 rtl/case_6_sdiv_13s_7s_13_seq_1.sv | 130 +++++++++++++
 1 files changed

// File: rtl/case_6_sdiv_13s_7s_13_seq_1.sv
// Multi-cycle signed divider (radix-2 restoring) for the case_6 datapath.
// Handshake: start is accepted when ready=1 and ce=1; done pulses in FIN with results valid.
module case_6_sdiv_13s_7s_13_seq_1 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] dividend0,
    input  logic [din1_WIDTH-1:0] divisor0,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] remd,
    output logic                  div_by_zero
);
    localparam int MW = din0_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                  state, state_next;
    logic                    accept;
    logic [CW-1:0]           cnt;
    logic [MW-1:0]           a_mag, b_mag, r;
    logic [din0_WIDTH-1:0]   q;
    logic                    sign_q, sign_r, dbz;
    logic [dout_WIDTH-1:0]   quot_q;
    logic [din1_WIDTH-1:0]   remd_q;
    logic                    dbz_q;

    logic [MW-1:0]           dvd_ext, dvs_ext, dvd_abs, dvs_abs;
    logic [MW:0]             r_shift;
    logic [MW+1:0]           diff;
    logic                    q_bit;
    logic [MW-1:0]           r_iter;
    logic [din1_WIDTH-1:0]   r_low;
    logic [dout_WIDTH-1:0]   fin_quot;
    logic [din1_WIDTH-1:0]   fin_remd;

    logic unused_id;
    assign unused_id = ^ID;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready      = (state == IDLE);
        done       = (state == FIN);
        case (state)
            IDLE: if (start) begin
                accept     = 1'b1;
                state_next = CALC;
            end
            CALC: if (cnt == '0) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One extra magnitude bit so that |-4096| is representable.
    always_comb begin
        dvd_ext = {dividend0[din0_WIDTH-1], dividend0};
        dvs_ext = {{(MW-din1_WIDTH){divisor0[din1_WIDTH-1]}}, divisor0};
        dvd_abs = dvd_ext[MW-1] ? -dvd_ext : dvd_ext;
        dvs_abs = dvs_ext[MW-1] ? -dvs_ext : dvs_ext;
    end

    always_comb begin
        r_shift = {r, a_mag[cnt]};
        diff    = {1'b0, r_shift} - {2'b00, b_mag};
        q_bit   = ~diff[MW+1];
        r_iter  = q_bit ? diff[MW-1:0] : r_shift[MW-1:0];
    end

    // The remainder is always below |divisor|, so its low bits carry the full magnitude.
    always_comb begin
        r_low    = r[din1_WIDTH-1:0];
        fin_quot = dbz ? '0 : (sign_q ? -q : q);
        fin_remd = dbz ? '0 : (sign_r ? -r_low : r_low);
        quot        = (state == FIN) ? fin_quot : quot_q;
        remd        = (state == FIN) ? fin_remd : remd_q;
        div_by_zero = (state == FIN) ? dbz : dbz_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            r      <= '0;
            q      <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dbz    <= 1'b0;
            quot_q <= '0;
            remd_q <= '0;
            dbz_q  <= 1'b0;
        end else if (ce) begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    a_mag  <= dvd_abs;
                    b_mag  <= dvs_abs;
                    sign_q <= dividend0[din0_WIDTH-1] ^ divisor0[din1_WIDTH-1];
                    sign_r <= dividend0[din0_WIDTH-1];
                    dbz    <= (divisor0 == '0);
                    r      <= '0;
                    q      <= '0;
                    cnt    <= CW'(din0_WIDTH - 1);
                end
                CALC: begin
                    r   <= r_iter;
                    q   <= {q[din0_WIDTH-2:0], q_bit};
                    cnt <= cnt - 1'b1;
                end
                FIN: begin
                    quot_q <= fin_quot;
                    remd_q <= fin_remd;
                    dbz_q  <= dbz;
                end
                default: ;
            endcase
        end
    end
endmodule
